// File: rtl/ifetch.sv
// Instruction fetch stage for the RV32I core.
// Holds the PC, issues word reads to instruction memory, buffers returned
// words in a small FIFO and presents them with their PC to decode through a
// valid/ready handshake. Redirects flush the buffer and mark every word still
// in flight as stale so it is dropped when it returns.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rest,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [31:0]   pc;
  logic [31:0]   head_pc;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;

  logic          pop;
  logic          grant;
  logic          wr_en;
  logic [CW:0]   occ_after_pop;
  logic [31:0]   target_pc;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign target_pc  = {redirect_pc[31:2], 2'b00};
  assign imem_addr  = pc;
  assign inst_valid = rest && (count != '0);
  assign inst       = inst_valid ? mem[rd_ptr] : NOP;
  assign inst_pc    = rest ? head_pc : RESET_PC;

  // Handshake decode: consume, issue limit, grant and FIFO write enable.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pop           = 1'b0;
    imem_req      = 1'b0;
    grant         = 1'b0;
    wr_en         = 1'b0;
    occ_after_pop = '0;

    pop           = inst_valid && inst_ready && !redirect;
    // Words owed to us plus words held, after this cycle's consume; a new
    // request is only issued when its response is sure to find a free slot.
    occ_after_pop = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};
    imem_req      = rest && !redirect && (occ_after_pop < {1'b0, DEPTH_C});
    grant         = imem_req && imem_gnt;
    wr_en         = rest && imem_rvalid && !redirect && (discard == '0);
  end

  // Control state: reset first, then redirect, then normal fetch bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    if (!rest) begin
      pc       <= RESET_PC;
      head_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect) begin
      pc       <= target_pc;
      head_pc  <= target_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // Everything still outstanding after this cycle is stale.
      inflight <= inflight - CW'(imem_rvalid);
      discard  <= inflight - CW'(imem_rvalid);
    end else begin
      if (grant) pc <= pc + 32'd4;
      inflight <= inflight + CW'(grant) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        head_pc <= head_pc + 32'd4;
      end
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // Instruction buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count gates every read, so stale
    // contents are never observed and the array can map onto plain flops/RAM.
    if (wr_en) mem[wr_ptr] <= imem_rdata;
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch. A single-cycle memory responder answers
// each grant one cycle later (optionally held back) with addr ^ A5A5_0000.
// Expected (pc, word) pairs are pushed to a scoreboard at each grant from the
// bench's own fetch-address model and popped when decode consumes a word.
module tb_ifetch;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rest, imem_gnt, imem_rvalid, redirect, inst_ready;
  logic        sel, hold;
  logic [31:0] imem_rdata, redirect_pc;

  logic        req_a, req_b, valid_a, valid_b;
  logic [31:0] addr_a, addr_b, inst_a, inst_b, pc_a, pc_b;
  logic        rest_a, rest_b, rvalid_a, rvalid_b;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;

  // Scoreboard and memory-model state.
  exp_t        sb_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] exp_fetch;
  int          stale;
  int          checks = 0;
  int          errors = 0;

  // Values observed in the most recent step.
  logic        obs_req, obs_valid, obs_grant, popped;
  logic [31:0] obs_addr, obs_inst, obs_pc, popped_pc;

  always #5 clk = ~clk;

  // Instance A uses the default reset PC; instance B checks PC wrap-around.
  // Only the selected instance is out of reset and sees memory responses.
  assign rest_a     = !sel && rest;
  assign rest_b     = sel && rest;
  assign rvalid_a   = !sel && imem_rvalid;
  assign rvalid_b   = sel && imem_rvalid;
  assign imem_req   = sel ? req_b   : req_a;
  assign imem_addr  = sel ? addr_b  : addr_a;
  assign inst_valid = sel ? valid_b : valid_a;
  assign inst       = sel ? inst_b  : inst_a;
  assign inst_pc    = sel ? pc_b    : pc_a;

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .rest        (rest_a),
    .imem_req    (req_a),
    .imem_addr   (addr_a),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (rvalid_a),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (valid_a),
    .inst        (inst_a),
    .inst_pc     (pc_a),
    .inst_ready  (inst_ready)
  );

  ifetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_dut_wrap (
    .clk         (clk),
    .rest        (rest_b),
    .imem_req    (req_b),
    .imem_addr   (addr_b),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (rvalid_b),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (valid_b),
    .inst        (inst_b),
    .inst_pc     (pc_b),
    .inst_ready  (inst_ready)
  );

  // One clock cycle: entered and left at a falling edge. Drives the memory
  // response, samples outputs mid-cycle, scores consumed words, then updates
  // the memory and scoreboard models with what happened at the rising edge.
  task automatic step();
    logic [31:0] ereset;
    logic        consumed;
    exp_t        e;
    ereset = sel ? WRAP_PC : 32'h0000_0000;
    if (!hold && pend_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_q[0] ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = inst_valid;
    obs_inst  = inst;
    obs_pc    = inst_pc;
    popped    = 1'b0;

    if (obs_valid !== 1'b1) begin
      checks++;
      if (obs_inst !== NOP) begin
        errors++;
        $display("FAIL idle_inst: got %h want %h", obs_inst, NOP);
      end
    end
    if (!rest || redirect) begin
      checks++;
      if (obs_req !== 1'b0) begin
        errors++;
        $display("FAIL req_blocked: got %b want 0 (rest=%b redirect=%b)", obs_req, rest, redirect);
      end
    end
    if (!rest) begin
      checks++;
      if (obs_valid !== 1'b0 || obs_pc !== ereset) begin
        errors++;
        $display("FAIL reset_outputs: got valid %b pc %h want valid 0 pc %h", obs_valid, obs_pc, ereset);
      end
    end
    if (obs_req === 1'b1) begin
      checks++;
      if (obs_addr !== exp_fetch) begin
        errors++;
        $display("FAIL fetch_addr: got %h want %h", obs_addr, exp_fetch);
      end
    end
    if (rest) begin
      checks++;
      if (sb_q.size() + stale > DEPTH) begin
        errors++;
        $display("FAIL occupancy: got %0d words owed want at most %0d", sb_q.size() + stale, DEPTH);
      end
    end

    consumed = rest && (obs_valid === 1'b1) && inst_ready && !redirect;
    if (consumed) begin
      checks++;
      popped    = 1'b1;
      popped_pc = obs_pc;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL inst_stream: got pc %h inst %h want nothing pending", obs_pc, obs_inst);
      end else begin
        e = sb_q.pop_front();
        if (obs_pc !== e.pc || obs_inst !== e.data) begin
          errors++;
          $display("FAIL inst_stream: got pc %h inst %h want pc %h inst %h",
                   obs_pc, obs_inst, e.pc, e.data);
        end
      end
    end
    obs_grant = rest && (obs_req === 1'b1) && imem_gnt;

    @(posedge clk);
    if (!rest) begin
      pend_q.delete();
      sb_q.delete();
      stale     = 0;
      exp_fetch = ereset;
    end else begin
      if (imem_rvalid) begin
        void'(pend_q.pop_front());
        if (!redirect && stale > 0) stale--;
      end
      if (redirect) begin
        stale     = pend_q.size();
        sb_q.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else if (obs_grant) begin
        pend_q.push_back(obs_addr);
        e.pc      = exp_fetch;
        e.data    = exp_fetch ^ KEY;
        sb_q.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0; rest = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; hold = 1'b0;
    step();
    step();
    checks++;
    if (obs_valid !== 1'b0 || obs_inst !== NOP || obs_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid %b inst %h req %b want 0 %h 0", obs_valid, obs_inst, obs_req, NOP);
    end
  endtask

  task automatic test_stream();
    rest = 1'b1;
    step();
    checks++;
    if (obs_grant !== 1'b1 || obs_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_request: got grant %b addr %h want 1 00000000", obs_grant, obs_addr);
    end
    step();
    checks++;
    if (obs_valid !== 1'b0 || obs_grant !== 1'b1) begin
      errors++;
      $display("FAIL stream_c1: got valid %b grant %b want 0 1", obs_valid, obs_grant);
    end
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_grant !== 1'b1) begin
      errors++;
      $display("FAIL first_valid: got valid %b pc %h grant %b want 1 00000000 1", obs_valid, obs_pc, obs_grant);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs_valid !== 1'b1 || obs_grant !== 1'b1) begin
        errors++;
        $display("FAIL no_bubble: cycle %0d got valid %b grant %b want 1 1", i, obs_valid, obs_grant);
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure: cycle %0d got req %b valid %b want 0 1", i, obs_req, obs_valid);
      end
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs_valid !== 1'b1) begin
        errors++;
        $display("FAIL resume: cycle %0d got valid %b want 1", i, obs_valid);
      end
    end
  endtask

  task automatic test_grant_stall();
    logic [31:0] held;
    held     = exp_fetch;
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== held) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got req %b addr %h want 1 %h", i, obs_req, obs_addr, held);
      end
    end
    imem_gnt = 1'b1;
    step();
    checks++;
    if (obs_grant !== 1'b1 || obs_addr !== held) begin
      errors++;
      $display("FAIL stall_grant: got grant %b addr %h want 1 %h", obs_grant, obs_addr, held);
    end
    step();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== held + 32'd4) begin
      errors++;
      $display("FAIL stall_advance: got req %b addr %h want 1 %h", obs_req, obs_addr, held + 32'd4);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  // Redirect from steady stream (1 buffered, 1 in flight) with the in-flight
  // response held back so it becomes stale and must be discarded.
  task automatic test_redirect(input logic [31:0] target, input logic [31:0] expect_pc);
    for (int i = 0; i < 4; i++) step();
    redirect    = 1'b1;
    redirect_pc = target;
    hold        = 1'b1;
    step();
    checks++;
    if (obs_valid !== 1'b1 || stale != 1) begin
      errors++;
      $display("FAIL redirect_setup: got valid %b stale %0d want 1 1", obs_valid, stale);
    end
    redirect = 1'b0;
    hold     = 1'b0;
    step();
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== expect_pc) begin
      errors++;
      $display("FAIL redirect_flush: got valid %b req %b addr %h want 0 1 %h", obs_valid, obs_req, obs_addr, expect_pc);
    end
    step();
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_drop: got valid %b pc %h want 0", obs_valid, obs_pc);
    end
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== expect_pc || obs_inst !== (expect_pc ^ KEY) || popped_pc !== expect_pc) begin
      errors++;
      $display("FAIL redirect_target: got valid %b pc %h inst %h want 1 %h %h",
               obs_valid, obs_pc, obs_inst, expect_pc, expect_pc ^ KEY);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    step();
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
      errors++;
      $display("FAIL full_before_reset: got valid %b req %b want 1 0", obs_valid, obs_req);
    end
    rest = 1'b0;
    step();
    step();
    checks++;
    if (obs_valid !== 1'b0 || obs_inst !== NOP || obs_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid %b inst %h req %b want 0 %h 0", obs_valid, obs_inst, obs_req, NOP);
    end
    rest       = 1'b1;
    inst_ready = 1'b1;
    step();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      errors++;
      $display("FAIL restart_addr: got req %b addr %h want 1 00000000", obs_req, obs_addr);
    end
    step();
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      errors++;
      $display("FAIL restart_pc: got valid %b pc %h want 1 00000000", obs_valid, obs_pc);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4];
    seq[0] = 32'hFFFF_FFF8;
    seq[1] = 32'hFFFF_FFFC;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0004;
    sel  = 1'b1;
    rest = 1'b0;
    step();
    step();
    rest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_grant !== 1'b1 || obs_addr !== seq[i]) begin
        errors++;
        $display("FAIL wrap_seq: index %0d got grant %b addr %h want 1 %h", i, obs_grant, obs_addr, seq[i]);
      end
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    sel = 1'b0; rest = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; hold = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stale = 0; exp_fetch = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_grant_stall();
    test_redirect(32'h0000_0100, 32'h0000_0100);
    test_redirect(32'h0000_0103, 32'h0000_0100);
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
